// File: rtl/score_sched_pkg.sv
// Shared widths, FSM state type and score clamp helper for the score CPU scheduler.
package score_sched_pkg;

    localparam int unsigned VAR_W     = 4;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned SCORE_MAX = 999;
    localparam int unsigned ID_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
    endfunction

endpackage

// File: rtl/score_cpu_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and wraps.
module rr_arbiter
    import score_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic               o_grant_valid,
    output logic [ID_W-1:0]    o_grant_id
);

    // Walk the farthest candidate first so the nearest requester wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            if (i_req[(32'(i_last_grant) + k) % NUM_REQ]) begin
                o_grant_valid = 1'b1;
                o_grant_id    = ID_W'((32'(i_last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/score_cpu_scheduler.sv
// Time-shares one score CPU between NUM_REQ requesters: reset, run window, capture, ack.
// Optional macro SCORE_CLAMP_EN limits the captured score to SCORE_MAX.
module score_cpu_scheduler
    import score_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned RUN_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [VAR_W*NUM_REQ-1:0]      req_var,
    input  logic [COORD_W*NUM_REQ-1:0]    req_rx,
    input  logic [COORD_W*NUM_REQ-1:0]    req_ry,
    input  logic [SCORE_W*NUM_REQ-1:0]    req_score,
    output logic [NUM_REQ-1:0]            ack,
    output logic [ID_W-1:0]               rsp_id,
    output logic [SCORE_W-1:0]            rsp_score,
    output logic [COORD_W-1:0]            rsp_offset_x,
    output logic [COORD_W-1:0]            rsp_offset_y,
    output logic                          busy,
    output logic                          cpu_reset,
    output logic [VAR_W-1:0]              cpu_var,
    output logic [COORD_W-1:0]            cpu_rx,
    output logic [COORD_W-1:0]            cpu_ry,
    output logic [SCORE_W-1:0]            cpu_cur_score,
    input  logic [SCORE_W-1:0]            cpu_score,
    input  logic [COORD_W-1:0]            cpu_offset_x,
    input  logic [COORD_W-1:0]            cpu_offset_y
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_e         r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_last_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic [ID_W-1:0]      r_rsp_id;
    logic [SCORE_W-1:0]   r_rsp_score;
    logic [COORD_W-1:0]   r_rsp_offset_x;
    logic [COORD_W-1:0]   r_rsp_offset_y;
    logic                 r_busy;
    logic                 r_cpu_reset;
    logic [VAR_W-1:0]     r_cpu_var;
    logic [COORD_W-1:0]   r_cpu_rx;
    logic [COORD_W-1:0]   r_cpu_ry;
    logic [SCORE_W-1:0]   r_cpu_cur_score;

    logic                 w_grant_valid;
    logic [ID_W-1:0]      w_grant_id;
    logic [SCORE_W-1:0]   w_cap_score;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req         (req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

`ifdef SCORE_CLAMP_EN
    assign w_cap_score = clamp_score(cpu_score);
`else
    assign w_cap_score = cpu_score;
`endif

    // Job sequencer; the counter is shared by CLEAR and RUN and restarts at each phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_last_grant    <= ID_W'(NUM_REQ - 1);
            r_ack           <= '0;
            r_rsp_id        <= '0;
            r_rsp_score     <= '0;
            r_rsp_offset_x  <= '0;
            r_rsp_offset_y  <= '0;
            r_busy          <= 1'b0;
            r_cpu_reset     <= 1'b1;
            r_cpu_var       <= '0;
            r_cpu_rx        <= '0;
            r_cpu_ry        <= '0;
            r_cpu_cur_score <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_cpu_var       <= req_var[int'(w_grant_id)*VAR_W +: VAR_W];
                        r_cpu_rx        <= req_rx[int'(w_grant_id)*COORD_W +: COORD_W];
                        r_cpu_ry        <= req_ry[int'(w_grant_id)*COORD_W +: COORD_W];
                        r_cpu_cur_score <= req_score[int'(w_grant_id)*SCORE_W +: SCORE_W];
                        r_rsp_id        <= w_grant_id;
                        r_last_grant    <= w_grant_id;
                        r_busy          <= 1'b1;
                        r_cnt           <= '0;
                        r_state         <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_cnt       <= '0;
                        r_cpu_reset <= 1'b0;
                        r_state     <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
                        r_cnt          <= '0;
                        r_rsp_score    <= w_cap_score;
                        r_rsp_offset_x <= cpu_offset_x;
                        r_rsp_offset_y <= cpu_offset_y;
                        r_ack          <= NUM_REQ'(1) << r_rsp_id;
                        r_cpu_reset    <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack           = r_ack;
    assign rsp_id        = r_rsp_id;
    assign rsp_score     = r_rsp_score;
    assign rsp_offset_x  = r_rsp_offset_x;
    assign rsp_offset_y  = r_rsp_offset_y;
    assign busy          = r_busy;
    assign cpu_reset     = r_cpu_reset;
    assign cpu_var       = r_cpu_var;
    assign cpu_rx        = r_cpu_rx;
    assign cpu_ry        = r_cpu_ry;
    assign cpu_cur_score = r_cpu_cur_score;

endmodule

// File: tb/tb_score_cpu_scheduler.sv
// Directed self-checking bench for score_cpu_scheduler with a simple behavioural CPU stand-in.
module tb_score_cpu_scheduler;

    localparam int unsigned NUM_REQ = 2;

    logic                 clk;
    logic                 reset;
    logic [1:0]           req;
    logic [7:0]           req_var;
    logic [21:0]          req_rx;
    logic [21:0]          req_ry;
    logic [19:0]          req_score;
    logic [1:0]           ack;
    logic [2:0]           rsp_id;
    logic [9:0]           rsp_score;
    logic [10:0]          rsp_offset_x;
    logic [10:0]          rsp_offset_y;
    logic                 busy;
    logic                 cpu_reset;
    logic [3:0]           cpu_var;
    logic [10:0]          cpu_rx;
    logic [10:0]          cpu_ry;
    logic [9:0]           cpu_cur_score;
    logic [9:0]           cpu_score;
    logic [10:0]          cpu_offset_x;
    logic [10:0]          cpu_offset_y;

    logic [9:0]           m_score;
    int                   n_cmp;
    int                   n_err;

    score_cpu_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .RST_CYCLES (2),
        .RUN_CYCLES (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_var       (req_var),
        .req_rx        (req_rx),
        .req_ry        (req_ry),
        .req_score     (req_score),
        .ack           (ack),
        .rsp_id        (rsp_id),
        .rsp_score     (rsp_score),
        .rsp_offset_x  (rsp_offset_x),
        .rsp_offset_y  (rsp_offset_y),
        .busy          (busy),
        .cpu_reset     (cpu_reset),
        .cpu_var       (cpu_var),
        .cpu_rx        (cpu_rx),
        .cpu_ry        (cpu_ry),
        .cpu_cur_score (cpu_cur_score),
        .cpu_score     (cpu_score),
        .cpu_offset_x  (cpu_offset_x),
        .cpu_offset_y  (cpu_offset_y)
    );

    // CPU stand-in: offsets derive from the latched coordinates so operand routing is visible.
    assign cpu_score    = cpu_reset ? 10'd0 : m_score;
    assign cpu_offset_x = cpu_reset ? 11'd0 : cpu_rx - 11'd95;
    assign cpu_offset_y = cpu_reset ? 11'd0 : cpu_ry - 11'd43;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance until ack is seen (sampled at negedge); lat=-1 on timeout.
    task automatic wait_ack(input int max_cyc, output int lat, output int low_cnt);
        lat     = -1;
        low_cnt = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!cpu_reset) low_cnt++;
            if (ack != 2'b00) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    int lat;
    int low;
    int ids [4];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req       = 2'b00;
        req_var   = '0;
        req_rx    = '0;
        req_ry    = '0;
        req_score = '0;
        m_score   = 10'd11;
        cycles(2);

        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_score", 32'(rsp_score), 0);
        check("rst_cpu_rx", 32'(cpu_rx), 0);
        reset = 1'b0;
        cycles(2);
        check("idle_no_req_busy", 32'(busy), 0);

        // Single request from requester 0
        req_var   = {4'd9, 4'd3};
        req_rx    = {11'd400, 11'd100};
        req_ry    = {11'd300, 11'd50};
        req_score = {10'd20, 10'd10};
        req       = 2'b01;
        wait_ack(200, lat, low);
        check("single_lat", 32'(lat), 67);
        check("single_ack", 32'(ack), 32'b01);
        check("single_id", 32'(rsp_id), 0);
        check("single_score", 32'(rsp_score), 11);
        check("single_offx", 32'(rsp_offset_x), 5);
        check("single_offy", 32'(rsp_offset_y), 7);
        check("single_run_len", 32'(low), 64);
        check("single_cpu_var", 32'(cpu_var), 3);
        check("single_cpu_cur", 32'(cpu_cur_score), 10);
        check("done_busy", 32'(busy), 1);
        check("done_cpu_reset", 32'(cpu_reset), 1);
        req = 2'b00;
        cycles(1);
        check("after_done_busy", 32'(busy), 0);
        check("after_done_ack", 32'(ack), 0);
        check("rsp_hold", 32'(rsp_score), 11);

        // Simultaneous requests from reset
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        req   = 2'b11;
        wait_ack(200, lat, low);
        check("simul0_lat", 32'(lat), 67);
        check("simul0_ack", 32'(ack), 32'b01);
        req = 2'b10;
        wait_ack(200, lat, low);
        check("simul1_lat", 32'(lat), 68);
        check("simul1_ack", 32'(ack), 32'b10);
        check("simul1_id", 32'(rsp_id), 1);
        check("simul1_offx", 32'(rsp_offset_x), 305);
        check("simul1_offy", 32'(rsp_offset_y), 257);
        check("simul1_cpu_var", 32'(cpu_var), 9);

        // Fairness: requester 1 holds, requester 0 re-requests after its ack
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ack(200, lat, low);
            ids[j] = int'(rsp_id);
            if (ack[0]) begin
                req = 2'b10;
                cycles(1);
                req = 2'b11;
            end
        end
        req = 2'b00;
        check("fair_0", 32'(ids[0]), 0);
        check("fair_1", 32'(ids[1]), 1);
        check("fair_2", 32'(ids[2]), 0);
        check("fair_3", 32'(ids[3]), 1);
        cycles(1);

        // Clamp behaviour
        m_score = 10'd1020;
        req     = 2'b01;
        wait_ack(200, lat, low);
        req = 2'b00;
`ifdef SCORE_CLAMP_EN
        check("clamp_score", 32'(rsp_score), 999);
`else
        check("clamp_score", 32'(rsp_score), 1020);
`endif
        m_score = 10'd11;
        cycles(1);

        // Reset mid-RUN: requester 1 is granted, reset drops the job, pointer restarts at 0
        req = 2'b11;
        cycles(3);
        check("mid_cpu_reset_run", 32'(cpu_reset), 0);
        check("mid_id", 32'(rsp_id), 1);
        cycles(29);
        reset = 1'b1;
        cycles(1);
        check("mid_busy", 32'(busy), 0);
        check("mid_cpu_reset", 32'(cpu_reset), 1);
        check("mid_ack", 32'(ack), 0);
        check("mid_rsp_score", 32'(rsp_score), 0);
        reset = 1'b0;
        wait_ack(200, lat, low);
        check("mid_regrant_lat", 32'(lat), 67);
        check("mid_regrant_id", 32'(rsp_id), 0);
        check("mid_regrant_score", 32'(rsp_score), 11);
        req = 2'b10;
        wait_ack(200, lat, low);
        check("mid_r1_lat", 32'(lat), 68);
        req = 2'b00;
        cycles(1);

        // Request drop and operand change mid-RUN
        req_rx = {11'd300, 11'd100};
        req    = 2'b10;
        cycles(20);
        req    = 2'b00;
        req_rx = {11'd7, 11'd100};
        wait_ack(200, lat, low);
        check("drop_lat", 32'(lat), 47);
        check("drop_ack", 32'(ack), 32'b10);
        check("drop_cpu_rx", 32'(cpu_rx), 300);
        check("drop_offx", 32'(rsp_offset_x), 205);
        cycles(2);
        check("drop_idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_cpu_scheduler.md
# score_cpu_scheduler

Shares one score CPU (the multicycle `cpu` core behind the score path) between `NUM_REQ` game-side requesters. Each requester supplies its own `var`, `rx`, `ry` and current score. The block grants requesters round-robin and holds the CPU in reset between jobs. For each job it releases the CPU for a fixed run window, captures the score and offset results, and returns them with a one-cycle acknowledge. It sits between the per-player game logic and the single CPU instance.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..8)
- `RST_CYCLES`, 2, cycles the CPU is held in reset before each job (≥1)
- `RUN_CYCLES`, 64, cycles the CPU runs before outputs are sampled (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req`  in  NUM_REQ  level request; held with its operands until `ack`
- `req_var`  in  4*NUM_REQ  per-requester `var`, slice i = bits [4i+3:4i]
- `req_rx`  in  11*NUM_REQ  per-requester rx
- `req_ry`  in  11*NUM_REQ  per-requester ry
- `req_score`  in  10*NUM_REQ  per-requester current score
- `ack`  out  NUM_REQ  one-cycle completion pulse to the granted requester
- `rsp_id`  out  3  index of the requester whose result is on the `rsp_*` outputs
- `rsp_score`  out  10  result score
- `rsp_offset_x`  out  11  result offsetX
- `rsp_offset_y`  out  11  result offsetY
- `busy`  out  1  high in any state other than IDLE
- `cpu_reset`  out  1  reset to CPU
- `cpu_var`  out  4  to CPU
- `cpu_rx`  out  11  to CPU
- `cpu_ry`  out  11  to CPU
- `cpu_cur_score`  out  10  to CPU
- `cpu_score`  in  10  from CPU
- `cpu_offset_x`  in  11  from CPU
- `cpu_offset_y`  in  11  from CPU

## Operation
- The FSM has four states: IDLE, CLEAR, RUN, DONE.
- **IDLE**
  - `cpu_reset`=1.
  - If any `req` is set, the arbiter picks the winner and the block latches its operands into the `cpu_*` operand registers and `rsp_id`, then moves to CLEAR.
  - With no request, the FSM stays in IDLE.
- **CLEAR**
  - `cpu_reset`=1 for `RST_CYCLES` cycles, then the FSM moves to RUN.
- **RUN**
  - `cpu_reset`=0 for `RUN_CYCLES` cycles.
  - On the edge that ends the last RUN cycle, the block registers `cpu_score`/`cpu_offset_x`/`cpu_offset_y` into `rsp_*` and moves to DONE.
- **DONE**
  - `ack[rsp_id]`=1 for this single cycle, and `cpu_reset`=1 again.
  - The FSM returns to IDLE unconditionally.
- **Arbitration**
  - Round-robin: search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - `last_grant` updates on each grant and resets to `NUM_REQ-1`, so requester 0 wins first.
- Operands are sampled only at grant. Changes to `req_*` during CLEAR/RUN are ignored.
- A requester that drops `req` mid-job does not abort it: the job completes and `ack` still pulses.
- Results hold in `rsp_*` until the next capture.

## Timing
- Reset values:
  - `cpu_reset`=1
  - `ack`=0, `busy`=0, `rsp_id`=0
  - `rsp_score`, `rsp_offset_x`, `rsp_offset_y`, and all `cpu_*` operand outputs = 0
  - state = IDLE
- Latency:
  - `req` seen in IDLE at cycle 0 gives `ack` high in cycle `1+RST_CYCLES+RUN_CYCLES` (67 with defaults).
  - `rsp_*` are valid in that same cycle.
- Throughput: one job per `2+RST_CYCLES+RUN_CYCLES` cycles. Back-to-back grants are separated by the DONE and IDLE cycles.
- Requesters drop `req` the cycle after `ack`. The IDLE cycle following DONE therefore never re-grants a completed requester.
- Reset asserted mid-job:
  - Immediate return to IDLE with all reset values.
  - `cpu_reset`=1, no `ack`, the job is lost.
  - The arbiter pointer resets.

## Configuration
- `SCORE_CLAMP_EN` defined: captured score is `min(cpu_score, 999)`, so any CPU output above 999 returns 999.
- `SCORE_CLAMP_EN` undefined: `cpu_score` passes to `rsp_score` unmodified, up to 1023.
- Offsets are never clamped.

## Structure
- Package `score_sched_pkg` holds:
  - the state enum (IDLE/CLEAR/RUN/DONE)
  - `VAR_W`=4, `COORD_W`=11, `SCORE_W`=10, `SCORE_MAX`=999
- Sub-module `rr_arbiter` takes `req` and `last_grant` and produces a `grant_valid` / `grant_id` pair. It is purely combinational; the pointer register stays in the parent.
- A single counter, sized for max(`RST_CYCLES`, `RUN_CYCLES`), is shared by CLEAR and RUN.

## Test plan
- **Single request:** `req`=2'b01, var=3, rx=100, ry=50, score=10, CPU model returns score 11 and offsets (5,7). Expect `ack`=01 at cycle 67, `rsp_id`=0, `rsp_score`=11, `cpu_reset` low for exactly 64 cycles.
- **Simultaneous requests:** `req`=2'b11 from reset. Requester 0 acks at cycle 67. Requester 1 is granted in the following IDLE cycle and acks 68 cycles after requester 0.
- **Fairness:** requester 0 re-requests immediately after each ack while requester 1 holds continuously. Grants must alternate 0,1,0,1.
- **Clamp:** CPU model returns 1020. With `SCORE_CLAMP_EN` expect `rsp_score`=999; without it, expect 1020.
- **Reset mid-RUN:** assert `reset` at RUN cycle 30. Next cycle shows `busy`=0, `cpu_reset`=1, no `ack`. After release, the held `req` is re-granted and completes normally.
- **Request drop and operand change:** drop `req` and change `req_rx` mid-RUN. `ack` still pulses, and `cpu_rx` keeps the value sampled at grant.
